// File: rtl/uart_pkg.sv
// Shared UART timing constants and receiver state encoding.
// The transmitter uses the same bit timing constants.
package uart_pkg;

    localparam int unsigned BAUD_END   = 5208;
    localparam int unsigned BAUD_MID   = BAUD_END / 2 - 1;
    localparam int unsigned BIT_END    = 9;
    localparam int unsigned BAUD_CNT_W = 13;
    localparam int unsigned BIT_CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Three-flop synchroniser for the asynchronous serial line.
// Also detects the falling edge that marks a start bit.
module uart_rx_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_rx,
    output logic o_rx_s2,
    output logic o_fall
);

    logic r_rx_s1;
    logic r_rx_s2;
    logic r_rx_s3;

    // Flops reset high so that a line idling high never looks like a start edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
            r_rx_s3 <= 1'b1;
        end else begin
            r_rx_s1 <= i_rx;
            r_rx_s2 <= r_rx_s1;
            r_rx_s3 <= r_rx_s2;
        end
    end

    assign o_rx_s2 = r_rx_s2;
    assign o_fall  = r_rx_s3 & ~r_rx_s2;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start detection, mid-bit sampling, and a single-cycle
// po_flag strobe per good byte or frame_err strobe per bad stop bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = uart_pkg::BAUD_END,
    parameter int unsigned SAMPLE_AT    = CLKS_PER_BIT / 2 - 1
) (
    input  logic       sclk,
    input  logic       s_rst_n,
    input  logic       rs232_rx,
    output logic [7:0] rx_data,
    output logic       po_flag,
    output logic       frame_err
);

    localparam logic [BAUD_CNT_W-1:0] BAUD_LAST = BAUD_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_CNT_W-1:0] BAUD_SAMP = BAUD_CNT_W'(SAMPLE_AT);
    localparam logic [BIT_CNT_W-1:0]  LAST_DATA = BIT_CNT_W'(BIT_END - 1);

    logic                  w_rx_s2;
    logic                  w_fall;
    logic                  w_samp;
    logic                  w_shift_en;
    logic                  w_good;
    logic                  w_bad;
    rx_state_t             r_state;
    rx_state_t             w_state_nxt;
    logic [BAUD_CNT_W-1:0] r_baud_cnt;
    logic [BIT_CNT_W-1:0]  r_bit_cnt;
    logic [BIT_CNT_W-1:0]  w_bit_cnt_nxt;
    logic [7:0]            r_shift;
    logic [7:0]            r_rx_data;
    logic                  r_po_flag;
    logic                  r_frame_err;

    uart_rx_sync u_sync (
        .i_clk   (sclk),
        .i_rst_n (s_rst_n),
        .i_rx    (rs232_rx),
        .o_rx_s2 (w_rx_s2),
        .o_fall  (w_fall)
    );

    assign w_samp = (r_state != IDLE) && (r_baud_cnt == BAUD_SAMP);

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_en    = 1'b0;
        w_good        = 1'b0;
        w_bad         = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_fall) begin
                    w_state_nxt = START;
                end
            end
            START: begin
                // A line back high at mid start bit was a glitch, not a frame.
                if (w_samp) begin
                    if (!w_rx_s2) begin
                        w_state_nxt   = DATA;
                        w_bit_cnt_nxt = BIT_CNT_W'(1);
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            DATA: begin
                if (w_samp) begin
                    w_shift_en    = 1'b1;
                    w_bit_cnt_nxt = r_bit_cnt + BIT_CNT_W'(1);
                    if (r_bit_cnt == LAST_DATA) begin
                        w_state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (w_samp) begin
                    w_good        = w_rx_s2;
                    w_bad         = ~w_rx_s2;
                    w_state_nxt   = IDLE;
                    w_bit_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_bit_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_baud_cnt <= '0;
        end else if (r_state == IDLE || r_baud_cnt == BAUD_LAST) begin
            r_baud_cnt <= '0;
        end else begin
            r_baud_cnt <= r_baud_cnt + BAUD_CNT_W'(1);
        end
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_shift     <= '0;
            r_rx_data   <= '0;
            r_po_flag   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_po_flag   <= w_good;
            r_frame_err <= w_bad;
            if (w_shift_en) begin
                r_shift <= {w_rx_s2, r_shift[7:1]};
            end
            if (w_good) begin
                r_rx_data <= r_shift;
            end
        end
    end

    assign rx_data   = r_rx_data;
    assign po_flag   = r_po_flag;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx using a shortened bit period and a
// frame-level reference model of received bytes and framing errors.
module tb_uart_rx;

    localparam int BE  = 104;
    localparam int MID = BE / 2 - 1;
    localparam int CLK = 10;

    logic       sclk     = 1'b0;
    logic       s_rst_n  = 1'b0;
    logic       rs232_rx = 1'b1;
    logic [7:0] rx_data;
    logic       po_flag;
    logic       frame_err;

    int n_checks = 0;
    int n_fail   = 0;

    time        q_t[$];
    logic [7:0] q_d[$];
    int         n_ferr = 0;
    int         n_both = 0;

    logic [7:0] exp_data = 8'h00;
    time        t_start  = 0;

    uart_rx #(.CLKS_PER_BIT(BE)) dut (
        .sclk      (sclk),
        .s_rst_n   (s_rst_n),
        .rs232_rx  (rs232_rx),
        .rx_data   (rx_data),
        .po_flag   (po_flag),
        .frame_err (frame_err)
    );

    always #(CLK / 2) sclk = ~sclk;

    // Record every strobe with the time of the edge that raised it.
    always @(posedge sclk) begin
        #1;
        if (po_flag) begin
            q_t.push_back($time - 1);
            q_d.push_back(rx_data);
        end
        if (frame_err) n_ferr++;
        if (po_flag && frame_err) n_both++;
    end

    initial begin
        #(200000 * CLK);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        q_t.delete();
        q_d.delete();
        n_ferr = 0;
    endtask

    task automatic idle(input int n);
        rs232_rx = 1'b1;
        repeat (n) @(negedge sclk);
    endtask

    // Drives one frame starting at the current negedge: start, 8 data LSB first, stop.
    task automatic send_byte(input logic [7:0] d, input int bitlen, input logic stop);
        logic [9:0] fr;
        fr = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rs232_rx = fr[i];
            if (i == 0) t_start = $time;
            repeat (bitlen) @(negedge sclk);
        end
        rs232_rx = 1'b1;
    endtask

    task automatic test_reset();
        s_rst_n = 1'b0;
        repeat (5) @(negedge sclk);
        n_checks++;
        if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %0h expected 0", rx_data); end
        n_checks++;
        if (po_flag !== 1'b0) begin n_fail++; $display("FAIL reset_po_flag: got %b expected 0", po_flag); end
        n_checks++;
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        s_rst_n = 1'b1;
        exp_data = 8'h00;
        idle(10);
        clear_mon();
    endtask

    task automatic test_single();
        logic [7:0] got;
        int lat;
        int exp_lat;
        clear_mon();
        send_byte(8'h55, BE, 1'b1);
        exp_data = 8'h55;
        idle(5);
        exp_lat = 9 * BE + MID + 3;
        got = (q_d.size() > 0) ? q_d[0] : 8'hxx;
        lat = (q_t.size() > 0) ? int'((q_t[0] - t_start) / CLK) : -1;
        n_checks++;
        if (q_d.size() !== 1) begin n_fail++; $display("FAIL single_pulses: got %0d expected 1", q_d.size()); end
        n_checks++;
        if (got !== 8'h55) begin n_fail++; $display("FAIL single_data: got %0h expected 55", got); end
        n_checks++;
        if (n_ferr !== 0) begin n_fail++; $display("FAIL single_ferr: got %0d expected 0", n_ferr); end
        n_checks++;
        if (lat < exp_lat - 1 || lat > exp_lat + 1) begin
            n_fail++; $display("FAIL single_latency: got %0d expected %0d +-1", lat, exp_lat);
        end
    endtask

    task automatic test_back_to_back();
        int gap;
        clear_mon();
        send_byte(8'hA3, BE, 1'b1);
        send_byte(8'h0F, BE, 1'b1);
        exp_data = 8'h0F;
        idle(5);
        n_checks++;
        if (q_d.size() !== 2) begin
            n_fail++; $display("FAIL b2b_pulses: got %0d expected 2", q_d.size());
        end else begin
            gap = int'((q_t[1] - q_t[0]) / CLK);
            n_checks++;
            if (q_d[0] !== 8'hA3) begin n_fail++; $display("FAIL b2b_first: got %0h expected a3", q_d[0]); end
            n_checks++;
            if (q_d[1] !== 8'h0F) begin n_fail++; $display("FAIL b2b_second: got %0h expected 0f", q_d[1]); end
            n_checks++;
            if (gap < 10 * BE - 1 || gap > 10 * BE + 1) begin
                n_fail++; $display("FAIL b2b_spacing: got %0d expected %0d +-1", gap, 10 * BE);
            end
        end
    endtask

    task automatic test_frame_error();
        clear_mon();
        send_byte(8'h3C, BE, 1'b0);
        idle(5);
        n_checks++;
        if (n_ferr !== 1) begin n_fail++; $display("FAIL ferr_count: got %0d expected 1", n_ferr); end
        n_checks++;
        if (q_d.size() !== 0) begin n_fail++; $display("FAIL ferr_no_pulse: got %0d expected 0", q_d.size()); end
        n_checks++;
        if (rx_data !== exp_data) begin n_fail++; $display("FAIL ferr_hold: got %0h expected %0h", rx_data, exp_data); end
        clear_mon();
        send_byte(8'h81, BE, 1'b1);
        exp_data = 8'h81;
        idle(5);
        n_checks++;
        if (q_d.size() !== 1 || rx_data !== 8'h81) begin
            n_fail++; $display("FAIL ferr_recover: got %0h (%0d pulses) expected 81 (1 pulse)", rx_data, q_d.size());
        end
    endtask

    task automatic test_glitch();
        clear_mon();
        rs232_rx = 1'b0;
        repeat (MID / 2) @(negedge sclk);
        idle(2 * BE);
        n_checks++;
        if (q_d.size() !== 0 || n_ferr !== 0) begin
            n_fail++; $display("FAIL glitch_ignored: got %0d pulses %0d ferr expected 0 0", q_d.size(), n_ferr);
        end
        send_byte(8'h7E, BE, 1'b1);
        exp_data = 8'h7E;
        idle(5);
        n_checks++;
        if (q_d.size() !== 1 || rx_data !== 8'h7E) begin
            n_fail++; $display("FAIL glitch_next: got %0h (%0d pulses) expected 7e (1 pulse)", rx_data, q_d.size());
        end
    endtask

    task automatic test_reset_midframe();
        clear_mon();
        fork
            send_byte(8'hFF, BE, 1'b1);
            begin
                repeat (4 * BE + BE / 2) @(negedge sclk);
                s_rst_n = 1'b0;
                repeat (3) @(negedge sclk);
                n_checks++;
                if (rx_data !== 8'h00) begin n_fail++; $display("FAIL midreset_clear: got %0h expected 0", rx_data); end
                s_rst_n = 1'b1;
            end
        join
        exp_data = 8'h00;
        idle(5);
        n_checks++;
        if (q_d.size() !== 0 || n_ferr !== 0) begin
            n_fail++; $display("FAIL midreset_abort: got %0d pulses %0d ferr expected 0 0", q_d.size(), n_ferr);
        end
        clear_mon();
        send_byte(8'h12, BE, 1'b1);
        exp_data = 8'h12;
        idle(5);
        n_checks++;
        if (q_d.size() !== 1 || rx_data !== 8'h12) begin
            n_fail++; $display("FAIL midreset_next: got %0h (%0d pulses) expected 12 (1 pulse)", rx_data, q_d.size());
        end
    endtask

    task automatic test_baud_sweep();
        int lens[2];
        lens[0] = 102;
        lens[1] = 106;
        foreach (lens[k]) begin
            clear_mon();
            send_byte(8'h96, lens[k], 1'b1);
            exp_data = 8'h96;
            idle(5);
            n_checks++;
            if (q_d.size() !== 1 || rx_data !== 8'h96 || n_ferr !== 0) begin
                n_fail++;
                $display("FAIL sweep_%0d: got %0h (%0d pulses %0d ferr) expected 96 (1 pulse 0 ferr)",
                         lens[k], rx_data, q_d.size(), n_ferr);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        int         exp_ferr;
        logic [7:0] d;
        logic       stop;
        int         bitlen;
        int         gap;
        exp_ferr = 0;
        clear_mon();
        for (int n = 0; n < 16; n++) begin
            d      = 8'($urandom);
            stop   = ($urandom_range(0, 3) != 0);
            bitlen = int'($urandom_range(102, 106));
            gap    = int'($urandom_range(0, 2));
            if (!stop && gap == 0) gap = 1;
            if (stop) begin
                exp_q.push_back(d);
                exp_data = d;
            end else begin
                exp_ferr++;
            end
            send_byte(d, bitlen, stop);
            idle(gap * bitlen);
        end
        idle(5);
        n_checks++;
        if (q_d.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL rand_pulses: got %0d expected %0d", q_d.size(), exp_q.size());
        end else begin
            foreach (exp_q[k]) begin
                n_checks++;
                if (q_d[k] !== exp_q[k]) begin
                    n_fail++; $display("FAIL rand_byte%0d: got %0h expected %0h", k, q_d[k], exp_q[k]);
                end
            end
        end
        n_checks++;
        if (n_ferr !== exp_ferr) begin n_fail++; $display("FAIL rand_ferr: got %0d expected %0d", n_ferr, exp_ferr); end
        n_checks++;
        if (rx_data !== exp_data) begin n_fail++; $display("FAIL rand_hold: got %0h expected %0h", rx_data, exp_data); end
    endtask

    task automatic test_exclusive();
        n_checks++;
        if (n_both !== 0) begin n_fail++; $display("FAIL exclusive_strobes: got %0d overlaps expected 0", n_both); end
    endtask

    initial begin
        @(negedge sclk);
        test_reset();
        test_single();
        test_back_to_back();
        test_frame_error();
        test_glitch();
        test_reset_midframe();
        test_baud_sweep();
        test_random();
        test_exclusive();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
